// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a small FIFO
// with a DATA/STATUS register read port.
module uart_rx_fifo #(
    parameter int DATA_WIDTH   = 32,
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  uart_rx,
    input  logic                  rd_i,
    input  logic                  addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rx_valid_o
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int BW   = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] FULL_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t          state, state_next;
    logic            sync1, sync2, rx_s;
    logic [BW-1:0]   baud_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic            par_bad;
    logic            tick, push_req, frame_set, parity_set;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CNTW-1:0] count;
    logic            full, pop, do_push, ovr_set, clr;
    logic            overrun, frame_err, parity_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= uart_rx;
            sync2 <= sync1;
        end
    end
    assign rx_s = sync2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // tick marks the cycle on which the current bit is sampled.
    always_comb begin
        state_next = state;
        tick       = 1'b0;
        push_req   = 1'b0;
        frame_set  = 1'b0;
        parity_set = 1'b0;
        case (state)
            IDLE: if (!rx_s) state_next = START;
            START: if (baud_cnt == HALF_LAST) begin
                tick       = 1'b1;
                state_next = rx_s ? IDLE : DATA;
            end
            DATA: if (baud_cnt == FULL_LAST) begin
                tick = 1'b1;
                if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (baud_cnt == FULL_LAST) begin
                tick       = 1'b1;
                parity_set = (^shift) ^ rx_s;
                state_next = STOP;
            end
`endif
            STOP: if (baud_cnt == FULL_LAST) begin
                tick       = 1'b1;
                push_req   = rx_s & ~par_bad;
                frame_set  = ~rx_s;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            baud_cnt <= (state == IDLE || tick) ? '0 : baud_cnt + 1'b1;
            if (state == START) bit_cnt <= '0;
            if (state == DATA && tick) begin
                shift   <= {rx_s, shift[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                      par_bad <= 1'b0;
        else if (state == IDLE)          par_bad <= 1'b0;
        else if (state == PARITY && tick) par_bad <= parity_set;
    end
`else
    assign par_bad = 1'b0;
`endif

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign full    = (count == CNTW'(FIFO_DEPTH));
    assign pop     = rd_i & ~addr_i & (count != '0);
    assign do_push = push_req & (~full | pop);
    assign ovr_set = push_req & full & ~pop;
    assign clr     = rd_i & addr_i;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= shift;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
            overrun    <= ovr_set    | (overrun    & ~clr);
            frame_err  <= frame_set  | (frame_err  & ~clr);
            parity_err <= parity_set | (parity_err & ~clr);
        end
    end

    assign rx_valid_o = (count != '0);

    always_comb begin
        rd_data_o = '0;
        if (addr_i) begin
            rd_data_o[0]         = rx_valid_o;
            rd_data_o[1]         = full;
            rd_data_o[2]         = overrun;
            rd_data_o[3]         = frame_err;
            rd_data_o[4]         = parity_err;
            rd_data_o[5 +: CNTW] = count;
        end else if (count != '0) begin
            rd_data_o[7:0] = mem[rd_ptr];
        end
    end
endmodule
